// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
//   Pops fetch-address queue entries and issues them as ICache read requests.
//   The unit tracks in-flight requests in order and buffers the ICache
//   responses. It delivers {vaddr, mask, instruction words} packets to the
//   instruction buffer under a valid/ready handshake. On a flush it discards
//   the responses to requests that were issued before the flush.
//
//   Optional build macro: FETCH_ISSUE_BYPASS_EN. When defined, a response that
//   arrives while the response buffer is empty is forwarded combinationally to
//   the ib_* outputs in the same cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush_i               pipeline flush / redirect
//   faq_*                 fetch address queue head (nempty, vaddr, slot mask) and pop
//   ic_req_*              ICache request (valid/ready, vaddr)
//   ic_rsp_*              ICache response (valid, data), in order, cannot be stalled
//   ib_*                  packet to instruction buffer (valid/ready, vaddr, mask, inst)
module fetch_issue_unit #(
  parameter int FETCH_WIDTH     = 4,
  parameter int VALEN           = 32,
  parameter int INST_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic                              faq_nempty_i,
  input  logic [VALEN-1:0]                  faq_vaddr_i,
  input  logic [FETCH_WIDTH-1:0]            faq_valid_i,
  output logic                              faq_pop_o,
  output logic                              ic_req_valid_o,
  input  logic                              ic_req_ready_i,
  output logic [VALEN-1:0]                  ic_req_vaddr_o,
  input  logic                              ic_rsp_valid_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] ic_rsp_data_i,
  output logic                              ib_valid_o,
  input  logic                              ib_ready_i,
  output logic [VALEN-1:0]                  ib_vaddr_o,
  output logic [FETCH_WIDTH-1:0]            ib_mask_o,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] ib_inst_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DW = FETCH_WIDTH * INST_WIDTH;

  logic [CW-1:0]          inflight, buffered, drop;

  logic [VALEN-1:0]       trk_vaddr [MAX_OUTSTANDING];
  logic [FETCH_WIDTH-1:0] trk_mask  [MAX_OUTSTANDING];
  logic [PW-1:0]          trk_wr, trk_rd;

  logic [VALEN-1:0]       buf_vaddr [MAX_OUTSTANDING];
  logic [FETCH_WIDTH-1:0] buf_mask  [MAX_OUTSTANDING];
  logic [DW-1:0]          buf_data  [MAX_OUTSTANDING];
  logic [PW-1:0]          buf_wr, buf_rd;

  logic credit_ok, issue, rsp_drop, rsp_live, rsp_take;
  logic buf_nempty, bypass, buf_push, buf_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both the in-flight requests and the held responses, so the
  // response buffer can never overflow.
  assign credit_ok      = ({1'b0, inflight} + {1'b0, buffered}) < (CW+1)'(MAX_OUTSTANDING);
  assign ic_req_valid_o = ~rst & ~flush_i & faq_nempty_i & credit_ok;
  assign faq_pop_o      = ic_req_valid_o & ic_req_ready_i;
  assign ic_req_vaddr_o = faq_vaddr_i;
  assign issue          = faq_pop_o;

  // A live response belongs to a request that was not flushed. A response
  // that arrives with nothing in flight and nothing to drop is ignored.
  assign rsp_drop   = ic_rsp_valid_i & (drop != '0);
  assign rsp_live   = ic_rsp_valid_i & (drop == '0) & (inflight != '0);
  assign rsp_take   = rsp_live & ~flush_i & ~rst;
  assign buf_nempty = (buffered != '0);

`ifdef FETCH_ISSUE_BYPASS_EN
  assign bypass = rsp_take & ~buf_nempty;
`else
  assign bypass = 1'b0;
`endif

  assign buf_push   = rsp_take & ~(bypass & ib_ready_i);
  assign buf_pop    = buf_nempty & ib_ready_i & ~flush_i & ~rst;
  assign ib_valid_o = ~rst & ~flush_i & (buf_nempty | bypass);
  assign ib_vaddr_o = bypass ? trk_vaddr[trk_rd] : buf_vaddr[buf_rd];
  assign ib_mask_o  = bypass ? trk_mask[trk_rd]  : buf_mask[buf_rd];
  assign ib_inst_o  = bypass ? ic_rsp_data_i     : buf_data[buf_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      buffered <= '0;
      drop     <= '0;
      trk_wr   <= '0;
      trk_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else if (flush_i) begin
      // Requests still in flight become drops, except one whose response is
      // being discarded in this very cycle.
      drop     <= inflight - CW'(rsp_live);
      inflight <= '0;
      buffered <= '0;
      trk_wr   <= '0;
      trk_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      if (issue)    trk_wr <= ptr_inc(trk_wr);
      if (rsp_take) trk_rd <= ptr_inc(trk_rd);
      if (buf_push) buf_wr <= ptr_inc(buf_wr);
      if (buf_pop)  buf_rd <= ptr_inc(buf_rd);
      if (rsp_drop) drop   <= drop - CW'(1);
      inflight <= inflight + CW'(issue) - CW'(rsp_take);
      buffered <= buffered + CW'(buf_push) - CW'(buf_pop);
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers and counters.
  always_ff @(posedge clk) begin
    if (issue) begin
      trk_vaddr[trk_wr] <= faq_vaddr_i;
      trk_mask[trk_wr]  <= faq_valid_i;
    end
    if (buf_push) begin
      buf_vaddr[buf_wr] <= trk_vaddr[trk_rd];
      buf_mask[buf_wr]  <= trk_mask[trk_rd];
      buf_data[buf_wr]  <= ic_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit (FETCH_WIDTH=4, VALEN=32,
// INST_WIDTH=32, MAX_OUTSTANDING=2). The bench models the fetch address queue
// and an in-order ICache with a configurable latency. A scoreboard queue of
// expected packets is filled when a request is issued and is checked on every
// instruction-buffer handshake.
module tb_fetch_issue_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_i = 1'b0;
  logic         faq_nempty_i = 1'b0;
  logic [31:0]  faq_vaddr_i = '0;
  logic [3:0]   faq_valid_i = '0;
  logic         faq_pop_o;
  logic         ic_req_valid_o;
  logic         ic_req_ready_i = 1'b0;
  logic [31:0]  ic_req_vaddr_o;
  logic         ic_rsp_valid_i = 1'b0;
  logic [127:0] ic_rsp_data_i = '0;
  logic         ib_valid_o;
  logic         ib_ready_i = 1'b0;
  logic [31:0]  ib_vaddr_o;
  logic [3:0]   ib_mask_o;
  logic [127:0] ib_inst_o;

  fetch_issue_unit #(
    .FETCH_WIDTH(4), .VALEN(32), .INST_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .faq_nempty_i(faq_nempty_i), .faq_vaddr_i(faq_vaddr_i), .faq_valid_i(faq_valid_i),
    .faq_pop_o(faq_pop_o),
    .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_req_ready_i),
    .ic_req_vaddr_o(ic_req_vaddr_o),
    .ic_rsp_valid_i(ic_rsp_valid_i), .ic_rsp_data_i(ic_rsp_data_i),
    .ib_valid_o(ib_valid_o), .ib_ready_i(ib_ready_i),
    .ib_vaddr_o(ib_vaddr_o), .ib_mask_o(ib_mask_o), .ib_inst_o(ib_inst_o)
  );

  always #5 clk = ~clk;

`ifdef FETCH_ISSUE_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct { logic [31:0] vaddr; logic [3:0] mask; } faq_t;
  typedef struct { logic [31:0] vaddr; int due; } rsp_t;
  typedef struct { logic [31:0] vaddr; logic [3:0] mask; logic [127:0] inst; } pkt_t;
  typedef struct { logic [31:0] vaddr; logic [3:0] mask; pkt_t exp; } vec_t;

  faq_t faq_q[$];
  rsp_t rsp_q[$];
  pkt_t exp_q[$];
  pkt_t got_q[$];
  vec_t vecs[20];

  int unsigned errors = 0, checks = 0;
  int cyc = 0, lat = 1, pop_cnt = 0, last_pop_cyc = 0, ibv_cyc = 0;
  logic rst_req = 1'b1, flush_req = 1'b0, ibr_req = 1'b0, icr_req = 1'b1;
  logic s_pop, s_req, s_ibv;
  logic hold_prev = 1'b0;
  logic [255:0] prev_payload = '0;

  function automatic logic [127:0] inst_of(input logic [31:0] va);
    return {va ^ 32'h3333_0000, va ^ 32'h2222_0000, va ^ 32'h1111_0000, va};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs on the falling edge, sample outputs 1ns later,
  // and update the queue/ICache/scoreboard models from the sampled handshakes.
  task automatic cycle();
    pkt_t e;
    @(negedge clk);
    cyc++;
    rst            = rst_req;
    flush_i        = flush_req;
    ib_ready_i     = ibr_req;
    ic_req_ready_i = icr_req;
    faq_nempty_i   = (faq_q.size() != 0);
    faq_vaddr_i    = faq_nempty_i ? faq_q[0].vaddr : '0;
    faq_valid_i    = faq_nempty_i ? faq_q[0].mask  : '0;
    ic_rsp_valid_i = 1'b0;
    ic_rsp_data_i  = '0;
    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      ic_rsp_valid_i = 1'b1;
      ic_rsp_data_i  = inst_of(rsp_q[0].vaddr);
      rsp_q.delete(0);
    end
    #1;
    s_pop = faq_pop_o;
    s_req = ic_req_valid_o;
    s_ibv = ib_valid_o;
    if (hold_prev && !rst && !flush_i) begin
      check("hold_valid", ib_valid_o, 1);
      check("hold_payload", {ib_vaddr_o, ib_mask_o, ib_inst_o}, prev_payload);
    end
    hold_prev    = ib_valid_o & ~ib_ready_i & ~rst & ~flush_i;
    prev_payload = {ib_vaddr_o, ib_mask_o, ib_inst_o};
    if (rst || flush_i) exp_q.delete();
    if (faq_pop_o) begin
      if (faq_q.size() == 0) begin
        check("spurious_pop", 1, 0);
      end else begin
        pop_cnt++;
        last_pop_cyc = cyc;
        rsp_q.push_back('{vaddr: faq_q[0].vaddr, due: cyc + lat});
        exp_q.push_back('{vaddr: faq_q[0].vaddr, mask: faq_q[0].mask,
                          inst: inst_of(faq_q[0].vaddr)});
        faq_q.delete(0);
      end
    end
    if (ib_valid_o && ibv_cyc == 0) ibv_cyc = cyc;
    if (ib_valid_o && ib_ready_i) begin
      got_q.push_back('{vaddr: ib_vaddr_o, mask: ib_mask_o, inst: ib_inst_o});
      if (exp_q.size() == 0) begin
        check("unexpected_packet", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_vaddr", ib_vaddr_o, e.vaddr);
        check("sb_mask",  ib_mask_o,  e.mask);
        check("sb_inst",  ib_inst_o,  e.inst);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic quiet_ok, stall_ok;
    int rel_cyc;

    for (int k = 0; k < 20; k++) begin
      vecs[k].vaddr = 32'h1000 + 32'(k) * 32'h10;
      vecs[k].mask  = 4'(k * 7 + 1);
      vecs[k].exp   = '{vaddr: vecs[k].vaddr, mask: vecs[k].mask, inst: inst_of(vecs[k].vaddr)};
    end

    // Reset with a pending queue entry; then single fetch.
    faq_q.push_back('{vaddr: 32'h1000, mask: 4'b1111});
    ibr_req = 1'b1;
    icr_req = 1'b1;
    cycle();
    cycle();
    check("reset_pop",   s_pop, 0);
    check("reset_req",   s_req, 0);
    check("reset_ibv",   s_ibv, 0);
    rst_req = 1'b0;
    pop_cnt = 0;
    ibv_cyc = 0;
    rel_cyc = cyc + 1;
    for (int i = 0; i < 8; i++) cycle();
    check("single_pops", pop_cnt, 1);
    check("single_first_issue", last_pop_cyc, rel_cyc);
    check("single_latency", ibv_cyc - last_pop_cyc, EXP_LAT);
    check("single_count", got_q.size(), 1);

    // Credit stall: 3 entries, consumer stalled, only two pops.
    got_q.delete();
    ibr_req = 1'b0;
    lat = 1;
    pop_cnt = 0;
    faq_q.push_back('{vaddr: 32'h1200, mask: 4'h1});
    faq_q.push_back('{vaddr: 32'h1210, mask: 4'h3});
    faq_q.push_back('{vaddr: 32'h1220, mask: 4'h7});
    stall_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i >= 2 && s_req) stall_ok = 1'b0;
    end
    check("credit_pops", pop_cnt, 2);
    check("credit_req_low", stall_ok, 1);
    ibr_req = 1'b1;
    cycle();
    check("credit_handshake_req", s_req, 0);
    check("credit_handshake_cnt", got_q.size(), 1);
    ibr_req = 1'b0;
    cycle();
    check("credit_freed_pop", s_pop, 1);
    ibr_req = 1'b1;
    for (int i = 0; i < 12 && got_q.size() < 3; i++) cycle();
    check("credit_drain", got_q.size(), 3);
    for (int i = 0; i < 3; i++) cycle();

    // Flush with two requests in flight (ICache latency 3).
    got_q.delete();
    lat = 3;
    pop_cnt = 0;
    faq_q.push_back('{vaddr: 32'h1300, mask: 4'hF});
    faq_q.push_back('{vaddr: 32'h1310, mask: 4'hE});
    for (int i = 0; i < 10 && pop_cnt < 2; i++) cycle();
    check("flush_setup_pops", pop_cnt, 2);
    faq_q.push_back('{vaddr: 32'h2000, mask: 4'hA});
    flush_req = 1'b1;
    cycle();
    check("flush_no_issue", s_pop, 0);
    flush_req = 1'b0;
    for (int i = 0; i < 15 && got_q.size() < 1; i++) cycle();
    for (int i = 0; i < 4; i++) cycle();
    check("flush_count", got_q.size(), 1);
    if (got_q.size() != 0) begin
      check("flush_vaddr", got_q[0].vaddr, 32'h2000);
      check("flush_mask",  got_q[0].mask,  4'hA);
    end

    // Streamed packets from the vector table with concurrent issue/response/consume.
    got_q.delete();
    lat = 1;
    pop_cnt = 0;
    for (int k = 0; k < 20; k++) faq_q.push_back('{vaddr: vecs[k].vaddr, mask: vecs[k].mask});
    for (int i = 0; i < 200 && got_q.size() < 20; i++) cycle();
    for (int i = 0; i < 3; i++) cycle();
    check("stream_count", got_q.size(), 20);
    check("stream_pops", pop_cnt, 20);
    for (int k = 0; k < 20; k++) begin
      if (k < got_q.size()) begin
        check("vec_vaddr", got_q[k].vaddr, vecs[k].exp.vaddr);
        check("vec_mask",  got_q[k].mask,  vecs[k].exp.mask);
        check("vec_inst",  got_q[k].inst,  vecs[k].exp.inst);
      end
    end

    // Reset mid-operation: one response buffered, one request in flight.
    got_q.delete();
    ibr_req = 1'b0;
    lat = 1;
    faq_q.push_back('{vaddr: 32'h1400, mask: 4'h5});
    cycle();
    lat = 4;
    faq_q.push_back('{vaddr: 32'h1410, mask: 4'h6});
    cycle();
    faq_q.push_back('{vaddr: 32'h1420, mask: 4'h7});
    cycle();
    check("midrst_credit_full", s_req, 0);
    rst_req = 1'b1;
    cycle();
    check("midrst_pop", s_pop, 0);
    check("midrst_req", s_req, 0);
    check("midrst_ibv", s_ibv, 0);
    rst_req = 1'b0;
    icr_req = 1'b0;
    ibr_req = 1'b1;
    lat = 1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (s_ibv) quiet_ok = 1'b0;
    end
    check("postrst_stray_ignored", quiet_ok, 1);
    check("postrst_req", s_req, 1);
    icr_req = 1'b1;
    for (int i = 0; i < 10 && got_q.size() < 1; i++) cycle();
    for (int i = 0; i < 3; i++) cycle();
    check("postrst_count", got_q.size(), 1);
    if (got_q.size() != 0) check("postrst_vaddr", got_q[0].vaddr, 32'h1420);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
